decay_buf_core: RTL and testbench
=================================

// Module: decay_buf_core
// PURPOSE
//  Triggered snapshot recorder for strobed waveform samples (e.g. cavity decay).
//  After a trigger it records 2**aw consecutive strobed samples, starting on a frame boundary, into a spare bank.
//  A reader sweeping read_addr then sees the record in chronological order.
//  Double-banked: the completed record becomes visible only at the start of a read frame (read_addr==0).
//  Single clock domain; sits between the DSP sample stream and the host readout.
// PARAMETERS
//  aw  6   log2 record depth; depth 64 samples, bank-select adds one RAM address bit
//  dw  16  sample width
// PORTS
//  clk        in   1   sole clock; everything on posedge
//  rst        in   1   asynchronous, active-high reset
//  d_in       in   dw  sample data, qualified by stb_in
//  stb_in     in   1   sample strobe
//  boundary   in   1   frame boundary marker (channel-set start); meaningful with or without stb_in
//  trig       in   1   single-cycle capture request
//  read_addr  in   aw  readout address; 0 = oldest sample of record
//  stb_out    in   1   read strobe
//  d_out      out  dw  read data, valid the cycle after stb_out
// BEHAVIOUR
//  - Reset: d_out=0, state IDLE, active (read) bank=0, pending=0, write pointer=0; RAM contents not reset.
//  - State IDLE: trig -> ARMED; other inputs ignored.
//  - State ARMED: on boundary -> RECORD, wptr=0.
//    If stb_in is high in the same cycle, that sample is written at address 0.
//  - State RECORD: each stb_in writes d_in to the spare bank (~active) at wptr, then wptr++.
//    The write of address 2**aw-1 sets pending=1 and moves to FULL.
//  - State FULL: holds until the swap happens, then -> IDLE.
//  - trig outside IDLE is ignored; no queueing of triggers.
//  - Swap: when stb_out & read_addr==0 & pending, active bank flips and pending clears in that cycle.
//    That same read already uses the new bank.
//    A record therefore never changes mid-sweep.
//  - Read: on stb_out, d_out <= ram[{active_after_swap, read_addr}]; latency 1 clk.
//    d_out holds its value when stb_out is low.
//  - Sample order: ram address k holds the k-th sample after the boundary.
//    With samples of a ramp every 4 clk, adjacent addresses differ by exactly +4 modulo 2**dw.
//  - wptr width aw; it wraps only at the transition to FULL.
//  - rst mid-record aborts the capture; active bank returns to 0, so an old record may reappear.
// CONFIGURATION
//  DECAY_BUF_STATUS_EN
//  - Defined: extra outputs
//      busy     1  high in ARMED or RECORD
//      pending  1  record complete, awaiting swap
//      nrec     8  count of completed swaps, wraps at 255, reset 0
//  - Undefined: these ports and the counter are absent; core behaviour is identical.
// STRUCTURE
//  - Package decay_buf_pkg: state enum {IDLE, ARMED, RECORD, FULL}, default aw/dw constants.
//  - Sub-module dpram: simple dual-port RAM, 2**(aw+1) x dw.
//    One write port and one registered read port, same clk.
//  - FSM, pointer, bank and swap logic stay in decay_buf_core.
// TESTING
//  - Ramp d_in=cycle count; stb_in every 4 clk; boundary every 8 clk; trig every 328 clk.
//    read_addr sweeps 0..63, one stb_out per 4 clk.
//    From the 2nd frame on, d_out(addr k) == d_out(addr k-1)+4 for k=1..63.
//  - Reset then read sweep before any trig -> no swap occurs, pending=0, busy=0.
//  - Single trig: busy rises next clk.
//    64 strobes after the boundary, pending=1.
//    Next stb_out at addr 0 flips the bank and pending=0.
//  - trig during RECORD and trig during FULL -> ignored; nrec increments by 1 only.
//  - Swap request while the reader sits mid-sweep (addr 30) -> addrs 30..63 still return the old record.
//    The new record appears from addr 0.
//  - rst asserted mid-RECORD (wptr=20) -> d_out=0 and state IDLE immediately.
//    A later trig produces a full, clean 64-sample record.

Source files
------------

// File: rtl/decay_buf_pkg.sv
// -----------------------------------------------------------------------------
// decay_buf_pkg
// Shared definitions for the triggered decay-snapshot recorder:
//   - capture FSM state encoding
//   - default record depth / sample width
//   - width of the completed-record counter (used when DECAY_BUF_STATUS_EN
//     is defined)
// -----------------------------------------------------------------------------
package decay_buf_pkg;

   localparam int AW_DEF = 6;   // log2 record depth (64 samples)
   localparam int DW_DEF = 16;  // sample width
   localparam int NREC_W = 8;   // completed-swap counter width

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      RECORD = 2'd2,
      FULL   = 2'd3
   } state_e;

endpackage : decay_buf_pkg

// File: rtl/decay_buf_if.sv
// -----------------------------------------------------------------------------
// decay_buf_if
// Bundles the sample stream, trigger and readout signals of decay_buf_core.
//   master : sample source / host side (drives stream, trigger, read address)
//   slave  : the recorder core
// Signals:
//   d_in[dw]       sample data, qualified by stb_in
//   stb_in         sample strobe
//   boundary       frame boundary marker
//   trig           single-cycle capture request
//   read_addr[aw]  readout address, 0 = oldest sample of the record
//   stb_out        read strobe
//   d_out[dw]      read data, valid the cycle after stb_out
// With DECAY_BUF_STATUS_EN defined, the core also drives:
//   busy           high while ARMED or RECORD
//   pending        record complete, awaiting swap
//   nrec[8]        completed swaps, wrapping
// -----------------------------------------------------------------------------
interface decay_buf_if
   import decay_buf_pkg::*;
#(
   parameter int aw = AW_DEF,
   parameter int dw = DW_DEF
) ();

   logic [dw-1:0] d_in;
   logic          stb_in;
   logic          boundary;
   logic          trig;
   logic [aw-1:0] read_addr;
   logic          stb_out;
   logic [dw-1:0] d_out;

`ifdef DECAY_BUF_STATUS_EN
   logic              busy;
   logic              pending;
   logic [NREC_W-1:0] nrec;

   modport master (
      output d_in, stb_in, boundary, trig, read_addr, stb_out,
      input  d_out, busy, pending, nrec
   );

   modport slave (
      input  d_in, stb_in, boundary, trig, read_addr, stb_out,
      output d_out, busy, pending, nrec
   );
`else
   modport master (
      output d_in, stb_in, boundary, trig, read_addr, stb_out,
      input  d_out
   );

   modport slave (
      input  d_in, stb_in, boundary, trig, read_addr, stb_out,
      output d_out
   );
`endif

endinterface : decay_buf_if

// File: rtl/decay_buf_dpram.sv
// -----------------------------------------------------------------------------
// decay_buf_dpram
// Simple dual-port RAM, 2**aw x dw, single clock.
// Ports:
//   clk       clock
//   rst       async active-high reset, clears the read register only
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   re_i      read enable; read register holds when low
//   raddr_i   read address
//   rdata_o   registered read data (latency 1)
// -----------------------------------------------------------------------------
module decay_buf_dpram #(
   parameter int aw = 7,
   parameter int dw = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [aw-1:0] waddr_i,
   input  logic [dw-1:0] wdata_i,
   input  logic          re_i,
   input  logic [aw-1:0] raddr_i,
   output logic [dw-1:0] rdata_o
);

   logic [dw-1:0] mem [2**aw];
   logic [dw-1:0] rdata_q;

   // NOTE: the array has no reset so it maps onto block RAM; only the output
   // register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule : decay_buf_dpram

// File: rtl/decay_buf_core.sv
// -----------------------------------------------------------------------------
// decay_buf_core
// Triggered, double-banked snapshot recorder. After trig, the next frame
// boundary starts a capture of 2**aw strobed samples into the spare bank.
// The finished record becomes readable only when the reader starts a new
// sweep (stb_out with read_addr == 0), so a record never changes mid-sweep.
// Ports:
//   clk   clock, posedge
//   rst   asynchronous, active-high reset
//   bus   decay_buf_if.slave (stream, trigger, readout, optional status)
// Optional feature macro: DECAY_BUF_STATUS_EN adds busy/pending/nrec status.
// -----------------------------------------------------------------------------
module decay_buf_core
   import decay_buf_pkg::*;
#(
   parameter int aw = AW_DEF,
   parameter int dw = DW_DEF
) (
   input logic        clk,
   input logic        rst,
   decay_buf_if.slave bus
);

   state_e        state_q;
   logic          active_q;   // bank the reader sees
   logic          pending_q;  // spare bank holds a complete record
   logic [aw-1:0] wptr_q;

   logic          swap;
   logic          wr_en;
   logic          wr_last;
   logic [aw-1:0] wr_addr;
   logic          rd_bank;
   logic [dw-1:0] rd_data;

   assign swap    = bus.stb_out && (bus.read_addr == '0) && pending_q;

   // The boundary cycle's own sample (if strobed) is the first of the record.
   assign wr_en   = bus.stb_in &&
                    (((state_q == ARMED) && bus.boundary) || (state_q == RECORD));
   assign wr_addr = (state_q == RECORD) ? wptr_q : '0;
   assign wr_last = &wr_addr;

   // The read that triggers the swap already sees the new bank.
   assign rd_bank = active_q ^ swap;

   // NOTE: all state here uses non-blocking assignments; later assignments in
   // the block deliberately override earlier ones for the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         active_q  <= 1'b0;
         pending_q <= 1'b0;
         wptr_q    <= '0;
      end else begin
         if (swap) begin
            active_q  <= ~active_q;
            pending_q <= 1'b0;
         end

         case (state_q)
            IDLE:   if (bus.trig) state_q <= ARMED;
            ARMED:  if (bus.boundary) begin
                       state_q <= RECORD;
                       wptr_q  <= '0;
                    end
            RECORD: ;
            FULL:   if (swap) state_q <= IDLE;
         endcase

         if (wr_en) begin
            if (wr_last) begin
               state_q   <= FULL;
               pending_q <= 1'b1;
               wptr_q    <= '0;
            end else begin
               wptr_q    <= wr_addr + 1'b1;
            end
         end
      end
   end

   decay_buf_dpram #(
      .aw (aw + 1),
      .dw (dw)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en),
      .waddr_i ({~active_q, wr_addr}),
      .wdata_i (bus.d_in),
      .re_i    (bus.stb_out),
      .raddr_i ({rd_bank, bus.read_addr}),
      .rdata_o (rd_data)
   );

   assign bus.d_out = rd_data;

`ifdef DECAY_BUF_STATUS_EN
   logic [NREC_W-1:0] nrec_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       nrec_q <= '0;
      else if (swap) nrec_q <= nrec_q + 1'b1;
   end

   assign bus.busy    = (state_q == ARMED) || (state_q == RECORD);
   assign bus.pending = pending_q;
   assign bus.nrec    = nrec_q;
`endif

endmodule : decay_buf_core

// File: tb/tb_decay_buf_core.sv
// -----------------------------------------------------------------------------
// tb_decay_buf_core
// Directed bench for decay_buf_core. The stream is a ramp (d_in = cycle
// count), strobed every 4 clk with a frame boundary every 8 clk, so a record
// captured from boundary cycle cb holds cb + 4*k at address k.
// Status checks are compiled in when DECAY_BUF_STATUS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decay_buf_core;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int N  = 2**AW;

   logic clk;
   logic rst;

   decay_buf_if #(.aw(AW), .dw(DW)) bus ();

   decay_buf_core #(.aw(AW), .dw(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc       = 0;
   int total     = 0;
   int bad       = 0;
   bit stream_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: stream inputs derive from cyc; pulses are cleared afterwards.
   task automatic step();
      bus.d_in     = cyc[DW-1:0];
      bus.stb_in   = stream_en && (cyc % 4 == 0);
      bus.boundary = stream_en && (cyc % 8 == 0);
      @(posedge clk);
      #1;
      cyc++;
      bus.trig    = 1'b0;
      bus.stb_out = 1'b0;
   endtask

   task automatic run_until(input int target);
      while (cyc < target) step();
   endtask

   // Reads addresses lo..hi, one per 4 clk; base < 0 means do not check data.
   task automatic sweep(input string tag, input int lo, input int hi, input int base);
      for (int a = lo; a <= hi; a++) begin
         bus.read_addr = a[AW-1:0];
         bus.stb_out   = 1'b1;
         step();
         if (base >= 0)
            check($sformatf("%s[%0d]", tag, a), {16'h0, bus.d_out},
                  (base + 4 * a) & 32'hFFFF);
         repeat (3) step();
      end
   endtask

   // Fires trig now and returns the boundary cycle that starts the record.
   task automatic fire_trig(output int cb);
      int ct;
      ct       = cyc;
      bus.trig = 1'b1;
      step();
      cb = (ct / 8 + 1) * 8;
   endtask

   int cb1, cb2, cb3, cb4;

   initial begin
      rst           = 1'b1;
      bus.d_in      = '0;
      bus.stb_in    = 1'b0;
      bus.boundary  = 1'b0;
      bus.trig      = 1'b0;
      bus.read_addr = '0;
      bus.stb_out   = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_dout", {16'h0, bus.d_out}, 32'd0);
`ifdef DECAY_BUF_STATUS_EN
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_pending", {31'h0, bus.pending}, 32'd0);
      check("rst_nrec", {24'h0, bus.nrec}, 32'd0);
`endif
      rst       = 1'b0;
      stream_en = 1'b1;
      repeat (5) step();

      // Sweep before any trigger: nothing to swap
      sweep("pre", 0, N - 1, -1);
`ifdef DECAY_BUF_STATUS_EN
      check("pre_busy", {31'h0, bus.busy}, 32'd0);
      check("pre_pending", {31'h0, bus.pending}, 32'd0);
      check("pre_nrec", {24'h0, bus.nrec}, 32'd0);
`endif

      // Single trigger, with extra triggers during RECORD and FULL
      fire_trig(cb1);
`ifdef DECAY_BUF_STATUS_EN
      check("trig_busy", {31'h0, bus.busy}, 32'd1);
`endif
      run_until(cb1 + 100);
      bus.trig = 1'b1;           // during RECORD: ignored
      step();
      run_until(cb1 + 4 * (N - 1));
`ifdef DECAY_BUF_STATUS_EN
      check("pre_full_pending", {31'h0, bus.pending}, 32'd0);
`endif
      run_until(cb1 + 4 * (N - 1) + 1);
`ifdef DECAY_BUF_STATUS_EN
      check("full_pending", {31'h0, bus.pending}, 32'd1);
      check("full_busy", {31'h0, bus.busy}, 32'd0);
`endif
      bus.trig = 1'b1;           // during FULL: ignored
      step();
      repeat (10) step();
      sweep("rec1", 0, N - 1, cb1);
`ifdef DECAY_BUF_STATUS_EN
      check("swap_pending", {31'h0, bus.pending}, 32'd0);
      check("swap_nrec", {24'h0, bus.nrec}, 32'd1);
      check("swap_busy", {31'h0, bus.busy}, 32'd0);
`endif
      // No queued trigger: the same record is still shown on the next sweep
      sweep("rec1_again", 0, N - 1, cb1);
`ifdef DECAY_BUF_STATUS_EN
      check("again_nrec", {24'h0, bus.nrec}, 32'd1);
`endif

      // Record completes while reader is mid-sweep
      sweep("mid_old_lo", 0, 29, cb1);
      fire_trig(cb2);
      run_until(cb2 + 4 * (N - 1) + 1);
`ifdef DECAY_BUF_STATUS_EN
      check("mid_pending", {31'h0, bus.pending}, 32'd1);
`endif
      sweep("mid_old_hi", 30, N - 1, cb1);
      sweep("rec2", 0, N - 1, cb2);
`ifdef DECAY_BUF_STATUS_EN
      check("rec2_nrec", {24'h0, bus.nrec}, 32'd2);
`endif

      // Reset in the middle of RECORD (wptr = 20)
      fire_trig(cb3);
      run_until(cb3 + 4 * 19 + 1);
      check("hold_dout", {16'h0, bus.d_out}, (cb2 + 4 * (N - 1)) & 32'hFFFF);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_dout", {16'h0, bus.d_out}, 32'd0);
`ifdef DECAY_BUF_STATUS_EN
      check("midrst_busy", {31'h0, bus.busy}, 32'd0);
      check("midrst_pending", {31'h0, bus.pending}, 32'd0);
      check("midrst_nrec", {24'h0, bus.nrec}, 32'd0);
`endif
      step();
      rst = 1'b0;
      repeat (3) step();
      // Bank 0 is active again and still holds the second record
      sweep("old_bank0", 0, 3, cb2);

      // Fresh capture after the aborted one is complete and clean
      fire_trig(cb4);
      run_until(cb4 + 4 * (N - 1) + 1);
`ifdef DECAY_BUF_STATUS_EN
      check("rec4_pending", {31'h0, bus.pending}, 32'd1);
`endif
      sweep("rec4", 0, N - 1, cb4);
`ifdef DECAY_BUF_STATUS_EN
      check("rec4_nrec", {24'h0, bus.nrec}, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_decay_buf_core
